// File: rtl/l2_cache_pkg.sv
// l2_cache_pkg: shared op encodings, lookup FSM states and line geometry for the L2 lookup controller
package l2_cache_pkg;
  localparam int OFFSET_BITS = 6;
  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_INVAL = 2'b10,
    OP_RSVD  = 2'b11
  } l2_op_e;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_COMPARE,
    S_WRITEBACK,
    S_FILL,
    S_UPDATE,
    S_RESP
  } l2_state_e;
  function automatic l2_op_e norm_op(input logic [1:0] op);
    return (op == OP_RSVD) ? OP_READ : l2_op_e'(op);
  endfunction
endpackage

// File: rtl/plru_tree.sv
// plru_tree: combinational tree-PLRU victim pick and touch update for one set (heap-ordered node bits)
module plru_tree #(
  parameter int WAYS = 8,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-2:0]  bits,
  input  logic [WAY_W-1:0] touch_way,
  output logic [WAY_W-1:0] victim,
  output logic [WAYS-2:0]  next_bits
);
  logic [WAY_W-1:0] vn, un;
  // node n has children 2n+1 (bit=0, lower half) and 2n+2 (bit=1, upper half)
  always_comb begin
    vn = '0;
    victim = '0;
    for (int l = 0; l < WAY_W; l++) begin
      victim[WAY_W-1-l] = bits[vn];
      vn = WAY_W'(2 * int'(vn) + 1 + int'(bits[vn]));
    end
  end
  always_comb begin
    un = '0;
    next_bits = bits;
    for (int l = 0; l < WAY_W; l++) begin
      next_bits[un] = ~touch_way[WAY_W-1-l];
      un = WAY_W'(2 * int'(un) + 1 + int'(touch_way[WAY_W-1-l]));
    end
  end
endmodule

// File: rtl/l2_lookup_ctrl.sv
// l2_lookup_ctrl: L2 lookup/miss FSM with per-set tree PLRU replacement.
// Define L2_STATS_EN to add saturating hitCount/missCount outputs.
module l2_lookup_ctrl
  import l2_cache_pkg::*;
#(
  parameter int WAYS = 8,
  parameter int SETS = 16,
  parameter int ADDR_BITS = 32,
  localparam int WAY_W = $clog2(WAYS),
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 reqValid,
  output logic                 reqReady,
  input  logic [1:0]           reqOp,
  input  logic [ADDR_BITS-1:0] reqAddr,
  output logic                 lookupEn,
  output logic [IDX_W-1:0]     lookupIndex,
  output logic [WAY_W-1:0]     victimWay,
  input  logic                 hit,
  input  logic [WAY_W-1:0]     hitWay,
  input  logic                 victimValid,
  input  logic                 victimDirty,
  output logic                 memReqValid,
  output logic                 memReqWrite,
  input  logic                 memAck,
  output logic                 wayWrite,
  output logic [WAY_W-1:0]     wayWriteSel,
  output logic                 wayWriteValid,
  output logic                 wayWriteDirty,
  output logic                 respValid,
  output logic                 respHit
`ifdef L2_STATS_EN
  ,
  output logic [31:0]          hitCount,
  output logic [31:0]          missCount
`endif
);
  l2_state_e state, state_n;
  l2_op_e op_q;
  logic [IDX_W-1:0] idx_q;
  logic [WAY_W-1:0] victim_q, hit_way_q, plru_victim, touch_way;
  logic hit_q;
  logic [SETS-1:0][WAYS-2:0] plru_q;
  logic [WAYS-2:0] plru_next;
  logic unused_addr;
  assign unused_addr = ^{reqAddr[ADDR_BITS-1:OFFSET_BITS+IDX_W], reqAddr[OFFSET_BITS-1:0]};
  // a hit touches the hit way, a miss touches the way it filled
  assign touch_way = hit_q ? hit_way_q : victim_q;
  plru_tree #(.WAYS(WAYS)) u_plru (
    .bits      (plru_q[idx_q]),
    .touch_way (touch_way),
    .victim    (plru_victim),
    .next_bits (plru_next)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      op_q <= OP_READ;
      idx_q <= '0;
      victim_q <= '0;
      hit_way_q <= '0;
      hit_q <= 1'b0;
      plru_q <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && reqValid) begin
        op_q <= norm_op(reqOp);
        idx_q <= reqAddr[OFFSET_BITS +: IDX_W];
      end
      if (state == S_LOOKUP) victim_q <= plru_victim;
      if (state == S_COMPARE) begin
        hit_q <= hit;
        hit_way_q <= hitWay;
      end
      if (state == S_RESP && op_q != OP_INVAL) plru_q[idx_q] <= plru_next;
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:      state_n = reqValid ? S_LOOKUP : S_IDLE;
      S_LOOKUP:    state_n = S_COMPARE;
      S_COMPARE:   state_n = hit ? ((op_q == OP_READ) ? S_RESP : S_UPDATE)
                                 : (op_q == OP_INVAL) ? S_RESP
                                 : (victimValid && victimDirty) ? S_WRITEBACK : S_FILL;
      S_WRITEBACK: state_n = memAck ? S_FILL : S_WRITEBACK;
      S_FILL:      state_n = memAck ? S_UPDATE : S_FILL;
      S_UPDATE:    state_n = S_RESP;
      S_RESP:      state_n = S_IDLE;
      default:     state_n = S_IDLE;
    endcase
    reqReady = rst_n && state == S_IDLE;
    lookupEn = state == S_LOOKUP;
    lookupIndex = idx_q;
    victimWay = (state == S_LOOKUP) ? plru_victim : victim_q;
    memReqValid = state == S_WRITEBACK || state == S_FILL;
    memReqWrite = state == S_WRITEBACK;
    wayWrite = state == S_UPDATE;
    wayWriteSel = touch_way;
    wayWriteValid = wayWrite && op_q != OP_INVAL;
    wayWriteDirty = wayWrite && op_q == OP_WRITE;
    respValid = state == S_RESP;
    respHit = respValid && hit_q;
  end
`ifdef L2_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hitCount <= '0;
      missCount <= '0;
    end else if (state == S_COMPARE && op_q != OP_INVAL) begin
      if (hit && !(&hitCount)) hitCount <= hitCount + 32'd1;
      if (!hit && !(&missCount)) missCount <= missCount + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_l2_lookup_ctrl.sv
// tb_l2_lookup_ctrl: directed scenario tasks for the L2 lookup controller
module tb_l2_lookup_ctrl;
  logic clk = 0;
  logic rst_n = 0;
  logic reqValid, reqReady, lookupEn, hit, victimValid, victimDirty;
  logic memReqValid, memReqWrite, memAck, wayWrite, wayWriteValid, wayWriteDirty, respValid, respHit;
  logic [1:0] reqOp;
  logic [31:0] reqAddr;
  logic [3:0] lookupIndex;
  logic [2:0] victimWay, hitWay, wayWriteSel;
`ifdef L2_STATS_EN
  logic [31:0] hitCount, missCount;
`endif
  int total = 0;
  int passed = 0;
  always #5 clk = ~clk;
  l2_lookup_ctrl dut (
    .clk(clk), .rst_n(rst_n), .reqValid(reqValid), .reqReady(reqReady), .reqOp(reqOp), .reqAddr(reqAddr),
    .lookupEn(lookupEn), .lookupIndex(lookupIndex), .victimWay(victimWay), .hit(hit), .hitWay(hitWay),
    .victimValid(victimValid), .victimDirty(victimDirty), .memReqValid(memReqValid), .memReqWrite(memReqWrite),
    .memAck(memAck), .wayWrite(wayWrite), .wayWriteSel(wayWriteSel), .wayWriteValid(wayWriteValid),
    .wayWriteDirty(wayWriteDirty), .respValid(respValid), .respHit(respHit)
`ifdef L2_STATS_EN
    , .hitCount(hitCount), .missCount(missCount)
`endif
  );
  task step;
    @(posedge clk);
    #1;
  endtask
  task do_reset;
    rst_n = 0;
    reqValid = 0; reqOp = 0; reqAddr = 0; hit = 0; hitWay = 0;
    victimValid = 0; victimDirty = 0; memAck = 0;
    #3;
    rst_n = 1;
    step;
  endtask
  task issue(input logic [1:0] op, input logic [31:0] addr);
    reqValid = 1; reqOp = op; reqAddr = addr;
    step;
    reqValid = 0;
  endtask
  task do_txn(input logic [1:0] op, input logic [31:0] addr, input logic h, input logic [2:0] hw,
              input logic vv, input logic vd);
    int n;
    issue(op, addr);
    hit = h; hitWay = hw; victimValid = vv; victimDirty = vd;
    n = 0;
    while (!respValid && n < 30) begin
      memAck = memReqValid;
      step;
      n++;
    end
    memAck = 0;
    total++; if (respValid !== 1'b1) $display("FAIL txn_timeout: respValid got %0b want 1", respValid); else passed++;
    step;
    hit = 0; victimValid = 0; victimDirty = 0;
  endtask
  task test_reset;
    reqValid = 0; reqOp = 0; reqAddr = 0; hit = 0; hitWay = 0;
    victimValid = 0; victimDirty = 0; memAck = 0;
    #2;
    total++; if (lookupEn !== 1'b0) $display("FAIL reset_lookupEn: got %0b want 0", lookupEn); else passed++;
    total++; if (memReqValid !== 1'b0) $display("FAIL reset_memReqValid: got %0b want 0", memReqValid); else passed++;
    total++; if (wayWrite !== 1'b0) $display("FAIL reset_wayWrite: got %0b want 0", wayWrite); else passed++;
    total++; if (respValid !== 1'b0) $display("FAIL reset_respValid: got %0b want 0", respValid); else passed++;
    rst_n = 1;
    step;
    total++; if (reqReady !== 1'b1) $display("FAIL reset_reqReady: got %0b want 1", reqReady); else passed++;
    total++; if (victimWay !== 3'd0) $display("FAIL reset_victimWay: got %0d want 0", victimWay); else passed++;
  endtask
  task test_read_hit;
    do_reset;
    issue(2'b00, 32'h0);
    hit = 1; hitWay = 2;
    total++; if (lookupEn !== 1'b1) $display("FAIL rdhit_lookupEn_c1: got %0b want 1", lookupEn); else passed++;
    total++; if (lookupIndex !== 4'd0) $display("FAIL rdhit_index: got %0d want 0", lookupIndex); else passed++;
    total++; if (reqReady !== 1'b0) $display("FAIL rdhit_reqReady_busy: got %0b want 0", reqReady); else passed++;
    step;
    total++; if (lookupEn !== 1'b0) $display("FAIL rdhit_lookupEn_c2: got %0b want 0", lookupEn); else passed++;
    total++; if (respValid !== 1'b0) $display("FAIL rdhit_resp_early: got %0b want 0", respValid); else passed++;
    step;
    total++; if (respValid !== 1'b1) $display("FAIL rdhit_respValid_c3: got %0b want 1", respValid); else passed++;
    total++; if (respHit !== 1'b1) $display("FAIL rdhit_respHit: got %0b want 1", respHit); else passed++;
    total++; if (wayWrite !== 1'b0) $display("FAIL rdhit_wayWrite: got %0b want 0", wayWrite); else passed++;
    total++; if (memReqValid !== 1'b0) $display("FAIL rdhit_memReqValid: got %0b want 0", memReqValid); else passed++;
    step;
    total++; if (respValid !== 1'b0) $display("FAIL rdhit_resp_pulse: got %0b want 0", respValid); else passed++;
    total++; if (reqReady !== 1'b1) $display("FAIL rdhit_back_idle: got %0b want 1", reqReady); else passed++;
    hit = 0;
  endtask
  task test_read_miss_fill;
    do_reset;
    issue(2'b00, 32'h0);
    total++; if (victimWay !== 3'd0) $display("FAIL rdmiss_victim0: got %0d want 0", victimWay); else passed++;
    hit = 0; victimValid = 0;
    step;
    step;
    total++; if (memReqValid !== 1'b1) $display("FAIL rdmiss_fill_req: got %0b want 1", memReqValid); else passed++;
    total++; if (memReqWrite !== 1'b0) $display("FAIL rdmiss_fill_write: got %0b want 0", memReqWrite); else passed++;
    repeat (5) step;
    total++; if (memReqValid !== 1'b1) $display("FAIL rdmiss_fill_hold: got %0b want 1", memReqValid); else passed++;
    memAck = 1;
    step;
    memAck = 0;
    total++; if (wayWrite !== 1'b1) $display("FAIL rdmiss_wayWrite: got %0b want 1", wayWrite); else passed++;
    total++; if (wayWriteSel !== 3'd0) $display("FAIL rdmiss_sel: got %0d want 0", wayWriteSel); else passed++;
    total++; if (wayWriteValid !== 1'b1) $display("FAIL rdmiss_valid: got %0b want 1", wayWriteValid); else passed++;
    total++; if (wayWriteDirty !== 1'b0) $display("FAIL rdmiss_dirty: got %0b want 0", wayWriteDirty); else passed++;
    total++; if (memReqValid !== 1'b0) $display("FAIL rdmiss_mem_drop: got %0b want 0", memReqValid); else passed++;
    step;
    total++; if (respValid !== 1'b1) $display("FAIL rdmiss_respValid: got %0b want 1", respValid); else passed++;
    total++; if (respHit !== 1'b0) $display("FAIL rdmiss_respHit: got %0b want 0", respHit); else passed++;
    total++; if (wayWrite !== 1'b0) $display("FAIL rdmiss_wayWrite_pulse: got %0b want 0", wayWrite); else passed++;
    step;
    issue(2'b00, 32'h0000_1000);
    total++; if (victimWay !== 3'd4) $display("FAIL rdmiss_victim4: got %0d want 4", victimWay); else passed++;
    hit = 1; hitWay = 4;
    step;
    total++; if (victimWay !== 3'd4) $display("FAIL rdmiss_victim_hold: got %0d want 4", victimWay); else passed++;
    step;
    step;
    hit = 0;
  endtask
  task test_write_miss_wb;
    do_reset;
    issue(2'b01, 32'h0000_00C0);
    total++; if (lookupIndex !== 4'd3) $display("FAIL wrmiss_index: got %0d want 3", lookupIndex); else passed++;
    hit = 0; victimValid = 1; victimDirty = 1;
    step;
    step;
    total++; if (memReqValid !== 1'b1) $display("FAIL wrmiss_wb_req: got %0b want 1", memReqValid); else passed++;
    total++; if (memReqWrite !== 1'b1) $display("FAIL wrmiss_wb_write: got %0b want 1", memReqWrite); else passed++;
    step;
    step;
    total++; if (memReqWrite !== 1'b1) $display("FAIL wrmiss_wb_hold: got %0b want 1", memReqWrite); else passed++;
    memAck = 1;
    step;
    memAck = 0;
    total++; if (memReqValid !== 1'b1) $display("FAIL wrmiss_fill_req: got %0b want 1", memReqValid); else passed++;
    total++; if (memReqWrite !== 1'b0) $display("FAIL wrmiss_fill_write: got %0b want 0", memReqWrite); else passed++;
    step;
    total++; if (memReqWrite !== 1'b0) $display("FAIL wrmiss_fill_hold: got %0b want 0", memReqWrite); else passed++;
    memAck = 1;
    step;
    memAck = 0;
    total++; if (wayWrite !== 1'b1) $display("FAIL wrmiss_wayWrite: got %0b want 1", wayWrite); else passed++;
    total++; if (wayWriteSel !== 3'd0) $display("FAIL wrmiss_sel: got %0d want 0", wayWriteSel); else passed++;
    total++; if (wayWriteDirty !== 1'b1) $display("FAIL wrmiss_dirty: got %0b want 1", wayWriteDirty); else passed++;
    step;
    total++; if (respValid !== 1'b1) $display("FAIL wrmiss_respValid: got %0b want 1", respValid); else passed++;
    total++; if (respHit !== 1'b0) $display("FAIL wrmiss_respHit: got %0b want 0", respHit); else passed++;
    step;
    victimValid = 0; victimDirty = 0;
  endtask
  task test_invalidate;
    do_reset;
    do_txn(2'b00, 32'h40, 1'b0, 3'd0, 1'b0, 1'b0);
    issue(2'b10, 32'h40);
    total++; if (victimWay !== 3'd4) $display("FAIL inv_victim_before: got %0d want 4", victimWay); else passed++;
    hit = 1; hitWay = 5;
    step;
    step;
    total++; if (wayWrite !== 1'b1) $display("FAIL inv_wayWrite: got %0b want 1", wayWrite); else passed++;
    total++; if (wayWriteSel !== 3'd5) $display("FAIL inv_sel: got %0d want 5", wayWriteSel); else passed++;
    total++; if (wayWriteValid !== 1'b0) $display("FAIL inv_valid: got %0b want 0", wayWriteValid); else passed++;
    total++; if (wayWriteDirty !== 1'b0) $display("FAIL inv_dirty: got %0b want 0", wayWriteDirty); else passed++;
    step;
    total++; if (respValid !== 1'b1) $display("FAIL inv_respValid: got %0b want 1", respValid); else passed++;
    total++; if (respHit !== 1'b1) $display("FAIL inv_respHit: got %0b want 1", respHit); else passed++;
    step;
    issue(2'b00, 32'h40);
    total++; if (victimWay !== 3'd4) $display("FAIL inv_plru_unchanged: got %0d want 4", victimWay); else passed++;
    hit = 1; hitWay = 1;
    step;
    step;
    step;
    issue(2'b10, 32'h80);
    hit = 0;
    step;
    step;
    total++; if (respValid !== 1'b1) $display("FAIL invmiss_respValid: got %0b want 1", respValid); else passed++;
    total++; if (respHit !== 1'b0) $display("FAIL invmiss_respHit: got %0b want 0", respHit); else passed++;
    total++; if (wayWrite !== 1'b0) $display("FAIL invmiss_wayWrite: got %0b want 0", wayWrite); else passed++;
    step;
  endtask
  task test_reset_in_fill;
    int bad;
    do_reset;
    issue(2'b00, 32'h100);
    hit = 0; victimValid = 0;
    step;
    step;
    total++; if (memReqValid !== 1'b1) $display("FAIL rstfill_in_fill: got %0b want 1", memReqValid); else passed++;
    #2;
    rst_n = 0;
    #1;
    total++; if (memReqValid !== 1'b0) $display("FAIL rstfill_mem_drop: got %0b want 0", memReqValid); else passed++;
    memAck = 1;
    #4;
    rst_n = 1;
    bad = 0;
    repeat (5) begin
      step;
      if (respValid || wayWrite || memReqValid) bad++;
    end
    memAck = 0;
    total++; if (bad !== 0) $display("FAIL rstfill_dropped: got %0d stray cycles want 0", bad); else passed++;
    total++; if (reqReady !== 1'b1) $display("FAIL rstfill_reqReady: got %0b want 1", reqReady); else passed++;
  endtask
  task test_back_to_back;
    do_reset;
    reqValid = 1; reqOp = 2'b00; reqAddr = 32'h40; hit = 1; hitWay = 0;
    step;
    reqOp = 2'b11; reqAddr = 32'h80;
    total++; if (lookupIndex !== 4'd1) $display("FAIL b2b_index1: got %0d want 1", lookupIndex); else passed++;
    step;
    step;
    total++; if (respValid !== 1'b1) $display("FAIL b2b_resp1: got %0b want 1", respValid); else passed++;
    step;
    total++; if (reqReady !== 1'b1) $display("FAIL b2b_ready: got %0b want 1", reqReady); else passed++;
    step;
    reqValid = 0;
    total++; if (lookupEn !== 1'b1) $display("FAIL b2b_lookup2: got %0b want 1", lookupEn); else passed++;
    total++; if (lookupIndex !== 4'd2) $display("FAIL b2b_index2: got %0d want 2", lookupIndex); else passed++;
    step;
    step;
    total++; if (respValid !== 1'b1) $display("FAIL b2b_rsvd_as_read: got %0b want 1", respValid); else passed++;
    total++; if (wayWrite !== 1'b0) $display("FAIL b2b_rsvd_wayWrite: got %0b want 0", wayWrite); else passed++;
    step;
    hit = 0;
  endtask
`ifdef L2_STATS_EN
  task test_stats;
    do_reset;
    total++; if (hitCount !== 32'd0) $display("FAIL stats_reset: got %0d want 0", hitCount); else passed++;
    do_txn(2'b00, 32'h0, 1'b1, 3'd1, 1'b0, 1'b0);
    do_txn(2'b01, 32'h40, 1'b1, 3'd2, 1'b0, 1'b0);
    do_txn(2'b00, 32'h80, 1'b1, 3'd3, 1'b0, 1'b0);
    do_txn(2'b00, 32'hC0, 1'b0, 3'd0, 1'b0, 1'b0);
    do_txn(2'b10, 32'hC0, 1'b0, 3'd0, 1'b0, 1'b0);
    do_txn(2'b10, 32'hC0, 1'b1, 3'd0, 1'b0, 1'b0);
    total++; if (hitCount !== 32'd3) $display("FAIL stats_hits: got %0d want 3", hitCount); else passed++;
    total++; if (missCount !== 32'd1) $display("FAIL stats_misses: got %0d want 1", missCount); else passed++;
  endtask
`endif
  initial begin
    test_reset;
    test_read_hit;
    test_read_miss_fill;
    test_write_miss_wb;
    test_invalidate;
    test_reset_in_fill;
    test_back_to_back;
`ifdef L2_STATS_EN
    test_stats;
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/l2_lookup_ctrl.md
L2_LOOKUP_CTRL -- requirements
Module: l2_lookup_ctrl

Interface
REQ-001 SHALL have parameter WAYS, default 8, associativity (power of 2, >=2).
REQ-002 SHALL have parameter SETS, default 16, sets tracked for replacement (power of 2).
REQ-003 SHALL have parameter ADDR_BITS, default 32, request address width; line offset fixed at 6 bits (64-byte line).
REQ-004 SHALL have ports: clk in 1 (single clock, all state on rising edge); rst_n in 1 (asynchronous, active-low reset).
REQ-005 SHALL have ports: reqValid in 1, new request; reqReady out 1, request accepted; reqOp in 2, operation (00 read, 01 write, 10 invalidate, 11 reserved = read); reqAddr in ADDR_BITS, byte address.
REQ-006 SHALL have ports: lookupEn out 1, tag/data array read strobe; lookupIndex out log2(SETS), set index; victimWay out log2(WAYS), replacement candidate.
REQ-007 SHALL have ports: hit in 1, hitWay in log2(WAYS), victimValid in 1, victimDirty in 1; hit-detector and array status for the strobed lookup.
REQ-008 SHALL have ports: memReqValid out 1, memReqWrite out 1 (1 writeback, 0 fill), memAck in 1, memory handshake.
REQ-009 SHALL have ports: wayWrite out 1, wayWriteSel out log2(WAYS), wayWriteValid out 1, wayWriteDirty out 1; tag/state update strobe.
REQ-010 SHALL have ports: respValid out 1, respHit out 1; completion pulse.

Function
REQ-011 SHALL implement FSM states IDLE, LOOKUP, COMPARE, WRITEBACK, FILL, UPDATE, RESP.
REQ-012 SHALL assert reqReady only in IDLE; reqValid&reqReady at an edge latches reqOp/reqAddr and moves to LOOKUP.
REQ-013 SHALL assert lookupEn for exactly the one LOOKUP cycle, with lookupIndex = latched addr[6 +: log2(SETS)] held stable from LOOKUP to RESP.
REQ-014 SHALL drive victimWay from the PLRU state of lookupIndex during LOOKUP and hold it through RESP; hit, hitWay, victimValid, victimDirty are sampled only in COMPARE.
REQ-015 COMPARE transitions: read hit -> RESP; write hit -> UPDATE (valid=1, dirty=1, sel=hitWay); invalidate hit -> UPDATE (valid=0, dirty=0, sel=hitWay); invalidate miss -> RESP; read/write miss -> WRITEBACK if victimValid&victimDirty, else FILL.
REQ-016 WRITEBACK and FILL SHALL hold memReqValid=1 until memAck sampled high (ack in the first cycle allowed); WRITEBACK -> FILL, FILL -> UPDATE (sel=victimWay, valid=1, dirty=1 for write, 0 for read).
REQ-017 SHALL pulse wayWrite for exactly one UPDATE cycle, then go to RESP.
REQ-018 SHALL pulse respValid for one RESP cycle (no backpressure) with respHit = hit sampled in COMPARE, then return to IDLE.
REQ-019 Read hit latency SHALL be 3 cycles: accept edge at cycle 0, respValid in cycle 3; write hit 4 cycles.
REQ-020 PLRU SHALL be a WAYS-1 bit tree per set; bit=0 selects lower half; on every read/write completion (hit or fill) the path bits of the touched way are set to point away from it; invalidates never touch PLRU.
REQ-021 memAck outside WRITEBACK/FILL SHALL be ignored.

Reset
REQ-022 rst_n low SHALL immediately force IDLE, clear all PLRU bits, drop any in-flight request (no respValid, no wayWrite) and drive all outputs 0 except reqReady=1 after release.

Configuration
REQ-023 With L2_STATS_EN defined, SHALL add outputs hitCount and missCount (32 bits each, saturating, cleared on reset), incremented in COMPARE for read/write ops only; without it those ports and counters SHALL not exist and behaviour is otherwise identical.

Structure
REQ-024 Op encodings, FSM state encoding and OFFSET_BITS=6 SHALL live in shared package l2_cache_pkg.
REQ-025 PLRU victim selection and update SHALL be sub-module plru_tree (combinational, WAYS parameter); state storage stays in l2_lookup_ctrl.

Verification
REQ-026 Reset, read addr 0x0000_0000, hit=1 hitWay=2 -> lookupEn cycle 1, respValid=1 respHit=1 in cycle 3, no wayWrite, no memReqValid.
REQ-027 After reset, read miss set 0, victimValid=0 -> victimWay=0, FILL, memAck after 5 cycles -> wayWrite sel=0 valid=1 dirty=0; next miss on set 0 -> victimWay=4.
REQ-028 Write miss, victimValid=1 victimDirty=1 -> memReqWrite=1 until ack, then memReqWrite=0 until ack, then wayWrite dirty=1, respHit=0.
REQ-029 Invalidate hit hitWay=5 -> wayWrite sel=5 valid=0; PLRU unchanged; invalidate miss -> respValid, no wayWrite.
REQ-030 rst_n low during FILL -> memReqValid=0 immediately, no respValid; with L2_STATS_EN, 3 hits + 1 miss -> hitCount=3 missCount=1.
